hex_disp_arb: RTL and testbench

HEX_DISP_ARB -- requirements
Module: hex_disp_arb

---
 rtl/hex_disp_pkg.sv | 13 +
 rtl/hex_disp_arb_rr_pick.sv | 32 +++
 rtl/hex_disp_arb.sv | 156 +++++++++++++++
 tb/tb_hex_disp_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display arbiter.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_t;

    localparam int HOLD_CYC_DEF = 50_000_000;
    localparam int IDX_W        = 3;

endpackage

// File: rtl/hex_disp_arb_rr_pick.sv
// Round-robin picker: first requester at or after start, wrapping at N-1 -> 0.
module rr_pick
    import hex_disp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             ofs;
    int             sum;

    // Rotate so that bit 0 of rot is requester 'start', then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        found = |rot;
        ofs   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) ofs = i;
        end
        sum = int'(start) + ofs;
        if (sum >= N) sum = sum - N;
        idx = IDX_W'(sum);
    end

endmodule

// File: rtl/hex_disp_arb.sv
// Round-robin arbiter sharing one 8-digit hex display among NREQ requesters.
// Optional requester-0 preemption is enabled by defining HEX_DISP_ARB_PREEMPT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no owner, display blanked, waiting for any request
// ST_OWN    | one requester owns the display, tenure counter running
// ST_SWITCH | one-cycle gap between owners, grant low, display held
module hex_disp_arb
    import hex_disp_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0][31:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          hex_out,
    output logic [2:0]           owner,
    output logic                 blank
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rr_ptr;

    logic [NREQ-1:0]  own_mask;
    logic             own_req;
    logic             oth_req;
    logic             cnt_sat;
    logic [31:0]      data_sel;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_found;
    logic             pre_hit;
    logic             go_switch;
    logic             go_idle;

    function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + 1'b1;
    endfunction

    rr_pick #(.N(NREQ)) u_rr_pick (
        .req   (req),
        .start (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        own_mask = NREQ'(1) << owner;
        own_req  = |(req & own_mask);
        oth_req  = |(req & ~own_mask);
        cnt_sat  = (cnt == CNT_W'(HOLD_CYC - 1));
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDX_W'(i)) data_sel = req_data[i];
        end
    end

`ifdef HEX_DISP_ARB_PREEMPT_EN
    logic pre_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pre_pend <= 1'b0;
        else          pre_pend <= (state == ST_OWN) && pre_hit;
    end

    // A pending preemption hands the display to requester 0 if it still asks.
    always_comb begin
        pre_hit   = req[0] && (owner != '0);
        nxt_idx   = pick_idx;
        nxt_found = pick_found;
        if (pre_pend && req[0]) begin
            nxt_idx   = '0;
            nxt_found = 1'b1;
        end
    end
`else
    always_comb begin
        pre_hit   = 1'b0;
        nxt_idx   = pick_idx;
        nxt_found = pick_found;
    end
`endif

    always_comb begin
        go_switch = pre_hit || (oth_req && (!own_req || cnt_sat));
        go_idle   = !own_req && !oth_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            owner   <= '0;
            hex_out <= '0;
            blank   <= 1'b1;
            cnt     <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state  <= ST_OWN;
                        owner  <= pick_idx;
                        gnt    <= NREQ'(1) << pick_idx;
                        blank  <= 1'b0;
                        cnt    <= '0;
                        rr_ptr <= inc_mod(pick_idx);
                    end
                end
                ST_OWN: begin
                    if (go_switch) begin
                        state   <= ST_SWITCH;
                        gnt     <= '0;
                        hex_out <= data_sel;
                    end else if (go_idle) begin
                        state   <= ST_IDLE;
                        gnt     <= '0;
                        blank   <= 1'b1;
                        hex_out <= '0;
                    end else begin
                        hex_out <= data_sel;
                        if (!cnt_sat) cnt <= cnt + 1'b1;
                    end
                end
                ST_SWITCH: begin
                    if (nxt_found) begin
                        state  <= ST_OWN;
                        owner  <= nxt_idx;
                        gnt    <= NREQ'(1) << nxt_idx;
                        cnt    <= '0;
                        rr_ptr <= inc_mod(nxt_idx);
                    end else begin
                        state   <= ST_IDLE;
                        blank   <= 1'b1;
                        hex_out <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    blank <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_disp_arb.sv
// Self-checking bench for hex_disp_arb: directed scenarios then random requests vs. a tenure model.
module tb_hex_disp_arb;

    localparam int NREQ     = 4;
    localparam int HOLD_CYC = 8;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][31:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [31:0]           hex_out;
    logic [2:0]            owner;
    logic                  blank;

    int checks = 0;
    int errors = 0;

    hex_disp_arb #(.NREQ(NREQ), .HOLD_CYC(HOLD_CYC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .hex_out  (hex_out),
        .owner    (owner),
        .blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who holds the display, for how many cycles, and where the next search starts.
    int          m_phase;   // 0 = nobody, 1 = held, 2 = handoff gap
    int          m_holder;
    int          m_tenure;
    int          m_next;
    bit          m_pre;
    logic [31:0] m_hex;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_req(input logic [NREQ-1:0] r, input int k);
        logic [NREQ-1:0] t;
        t = r >> k;
        return t[0];
    endfunction

    function automatic int first_from(input logic [NREQ-1:0] r, input int start);
        for (int i = 0; i < NREQ; i++) begin
            if (has_req(r, (start + i) % NREQ)) return (start + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input int h);
        logic [NREQ*32-1:0] t;
        t = req_data >> (32 * h);
        return t[31:0];
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_holder = 0;
        m_tenure = 0;
        m_next   = 0;
        m_pre    = 1'b0;
        m_hex    = '0;
    endtask

    task automatic grant_to(input int s);
        m_phase  = 1;
        m_holder = s;
        m_tenure = 1;
        m_next   = (s + 1) % NREQ;
    endtask

    task automatic model_step();
        int  s;
        bit  mine, others, preempt;
        case (m_phase)
            0: begin
                s = first_from(req, m_next);
                if (s >= 0) grant_to(s);
            end
            1: begin
                mine    = has_req(req, m_holder);
                others  = (req & ~(NREQ'(1) << m_holder)) != '0;
`ifdef HEX_DISP_ARB_PREEMPT_EN
                preempt = has_req(req, 0) && (m_holder != 0);
`else
                preempt = 1'b0;
`endif
                if (preempt || (others && (!mine || m_tenure >= HOLD_CYC))) begin
                    m_phase = 2;
                    m_pre   = preempt;
                    m_hex   = word_of(m_holder);
                end else if (!mine) begin
                    m_phase = 0;
                    m_hex   = '0;
                end else begin
                    m_hex    = word_of(m_holder);
                    m_tenure = m_tenure + 1;
                end
            end
            default: begin
                s = (m_pre && has_req(req, 0)) ? 0 : first_from(req, (m_holder + 1) % NREQ);
                m_pre = 1'b0;
                if (s >= 0) grant_to(s);
                else begin
                    m_phase = 0;
                    m_hex   = '0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] eg;
        eg = (m_phase == 1) ? (NREQ'(1) << m_holder) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("blank", 32'(blank), 32'(m_phase == 0));
        chk("hex_out", hex_out, m_hex);
        if (m_phase == 1) chk("owner", 32'(owner), 32'(m_holder));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic new_data();
        req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        req_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_hex", hex_out, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        reset_n = 1'b1;

        // Single requester: grant after one cycle, data one cycle later.
        new_data();
        step(2);
        req = 4'b0001;
        step(1);
        chk("first_gnt", 32'(gnt), 32'h1);
        step(1);
        chk("first_hex", hex_out, req_data[0]);

        // Two requesters alternate after HOLD_CYC cycles each.
        req = 4'b0011;
        step(30);

        // Owner 3 hands back to 0 through the wrap.
        req = 4'b0000;
        step(3);
        req = 4'b1000;
        step(3);
        req = 4'b1001;
        step(15);

        // Owner 1 alone drops its request.
        req = 4'b0000;
        step(3);
        req = 4'b0010;
        new_data();
        step(4);
        req = 4'b0000;
        step(1);
        chk("drop_blank", 32'(blank), 32'd1);
        chk("drop_hex", hex_out, 32'd0);
        step(2);

        // Owner 2 at counter 1, then requester 0 asks.
        req = 4'b0100;
        step(2);
        req = 4'b0101;
        step(14);

        // Short asynchronous reset mid-tenure.
        req = 4'b0110;
        step(3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_blank", 32'(blank), 32'd1);
        #2 reset_n = 1'b1;
        model_reset();
        req = 4'b1111;
        step(1);
        chk("arst_restart", 32'(gnt), 32'h1);
        step(20);

        // Random request churn.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 9) == 0) req = req ^ (NREQ'(1) << b);
            end
            if ($urandom_range(0, 3) == 0) new_data();
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
